// File: rtl/middle_nonlinear_pipe.sv
// Multi-lane pipelined middle nonlinear section of the depth-16 Boyar-Peralta AES S-box.
// Maps top-linear terms T0..T26 plus D to the shared nonlinear terms M0..M62 per lane.

module mnl_lane #(
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [STAGES-1:0] ld,
  input  logic              en,
  input  logic [26:0]       t,
  input  logic              d,
  output logic [62:0]       m
);

  // M0..M22: everything up to the first cut
  function automatic logic [22:0] mid_a(input logic [26:0] ti, input logic di);
    logic [22:0] r;
    r[0]  = ti[12] & ti[5];
    r[1]  = ti[22] & ti[7];
    r[2]  = ti[13] ^ r[0];
    r[3]  = ti[18] & di;
    r[4]  = r[3] ^ r[0];
    r[5]  = ti[2] & ti[15];
    r[6]  = ti[21] & ti[8];
    r[7]  = ti[25] ^ r[5];
    r[8]  = ti[19] & ti[16];
    r[9]  = r[8] ^ r[5];
    r[10] = ti[0] & ti[14];
    r[11] = ti[3] & ti[26];
    r[12] = r[11] ^ r[10];
    r[13] = ti[1] & ti[9];
    r[14] = r[13] ^ r[10];
    r[15] = r[2] ^ r[1];
    r[16] = r[4] ^ ti[23];
    r[17] = r[7] ^ r[6];
    r[18] = r[9] ^ r[14];
    r[19] = r[15] ^ r[12];
    r[20] = r[16] ^ r[14];
    r[21] = r[17] ^ r[12];
    r[22] = r[18] ^ ti[24];
    return r;
  endfunction

  // M23..M44: GF(2^4) inversion core, depends only on M19..M22
  function automatic logic [44:0] mid_b(input logic [22:0] mi);
    logic [44:0] r;
    r[22:0] = mi;
    r[23] = r[21] ^ r[22];
    r[24] = r[21] & r[19];
    r[25] = r[20] ^ r[24];
    r[26] = r[19] ^ r[20];
    r[27] = r[22] ^ r[24];
    r[28] = r[27] & r[26];
    r[29] = r[25] & r[23];
    r[30] = r[19] & r[22];
    r[31] = r[26] & r[30];
    r[32] = r[26] ^ r[24];
    r[33] = r[20] & r[21];
    r[34] = r[23] & r[33];
    r[35] = r[23] ^ r[24];
    r[36] = r[20] ^ r[28];
    r[37] = r[31] ^ r[32];
    r[38] = r[22] ^ r[29];
    r[39] = r[34] ^ r[35];
    r[40] = r[37] ^ r[39];
    r[41] = r[36] ^ r[38];
    r[42] = r[36] ^ r[37];
    r[43] = r[38] ^ r[39];
    r[44] = r[41] ^ r[40];
    return r;
  endfunction

  // M45..M62: final multiplications against the carried T/D terms
  function automatic logic [62:0] mid_c(input logic [44:0] mi, input logic [26:0] ti,
                                        input logic di);
    logic [62:0] r;
    r[44:0] = mi;
    r[45] = r[43] & ti[5];
    r[46] = r[39] & ti[7];
    r[47] = r[38] & di;
    r[48] = r[42] & ti[15];
    r[49] = r[37] & ti[8];
    r[50] = r[36] & ti[16];
    r[51] = r[41] & ti[14];
    r[52] = r[44] & ti[26];
    r[53] = r[40] & ti[9];
    r[54] = r[43] & ti[12];
    r[55] = r[39] & ti[22];
    r[56] = r[38] & ti[18];
    r[57] = r[42] & ti[2];
    r[58] = r[37] & ti[21];
    r[59] = r[36] & ti[19];
    r[60] = r[41] & ti[0];
    r[61] = r[44] & ti[3];
    r[62] = r[40] & ti[1];
    return r;
  endfunction

  // A disabled lane enters as all-zero; the function maps zero to zero downstream.
  logic [26:0] tz;
  logic        dz;
  assign tz = en ? t : '0;
  assign dz = en & d;

  if (STAGES == 1) begin : g_s1
    always_ff @(posedge clk)
      if (!reset_n)   m <= '0;
      else if (ld[0]) m <= mid_c(mid_b(mid_a(tz, dz)), tz, dz);
  end else begin : g_sn
    // Only the T terms needed by the last multiplication layer are carried.
    localparam logic [26:0] CARRY = 27'h46DD3AF;
    logic [22:0] a_m;
    logic [26:0] a_t;
    logic        a_d;

    always_ff @(posedge clk)
      if (!reset_n) begin
        a_m <= '0;
        a_t <= '0;
        a_d <= 1'b0;
      end else if (ld[0]) begin
        a_m <= mid_a(tz, dz);
        a_t <= tz & CARRY;
        a_d <= dz;
      end

    if (STAGES == 2) begin : g_s2
      always_ff @(posedge clk)
        if (!reset_n)   m <= '0;
        else if (ld[1]) m <= mid_c(mid_b(a_m), a_t, a_d);
    end else begin : g_s3
      logic [44:0] b_m;
      logic [26:0] b_t;
      logic        b_d;

      always_ff @(posedge clk)
        if (!reset_n) begin
          b_m <= '0;
          b_t <= '0;
          b_d <= 1'b0;
        end else if (ld[1]) begin
          b_m <= mid_b(a_m);
          b_t <= a_t;
          b_d <= a_d;
        end

      always_ff @(posedge clk)
        if (!reset_n)   m <= '0;
        else if (ld[2]) m <= mid_c(b_m, b_t, b_d);
    end
  end

endmodule

module middle_nonlinear_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [27*LANES-1:0]   in_t,
  input  logic [LANES-1:0]      in_d,
  input  logic [LANES-1:0]      in_lane_en,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63*LANES-1:0]   out_m,
  output logic [LANES-1:0]      out_lane_en,
  output logic [TAG_W-1:0]      out_tag,
  output logic [1:0]            occupancy
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("middle_nonlinear_pipe: STAGES must be 1, 2 or 3");
  end
  if (LANES < 1 || LANES > 16 || TAG_W < 1) begin : g_bad_dims
    $error("middle_nonlinear_pipe: LANES must be 1..16 and TAG_W >= 1");
  end

  logic [STAGES-1:0]            v, room, adv, ld;
  logic [STAGES-1:0][LANES-1:0] en_q;
  logic [STAGES-1:0][TAG_W-1:0] tag_q;

  // Walk back from the output: a stage has room if it or anything after it can drain.
  always_comb begin
    logic r;
    r    = out_ready;
    room = '0;
    adv  = '0;
    ld   = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s]  = v[s] & r;
      r       = r | ~v[s];
      room[s] = r;
    end
    ld[0] = in_valid & reset_n & room[0];
    for (int s = 1; s < STAGES; s++) ld[s] = adv[s-1];
  end

  assign in_ready = reset_n & room[0];

  always_ff @(posedge clk)
    if (!reset_n) begin
      v     <= '0;
      en_q  <= '0;
      tag_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++)
        if (ld[s])       v[s] <= 1'b1;
        else if (adv[s]) v[s] <= 1'b0;
      if (ld[0]) begin
        en_q[0]  <= in_lane_en;
        tag_q[0] <= in_tag;
      end
      for (int s = 1; s < STAGES; s++)
        if (ld[s]) begin
          en_q[s]  <= en_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
    end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mnl_lane #(.STAGES(STAGES)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .ld      (ld),
      .en      (in_lane_en[k]),
      .t       (in_t[27*k +: 27]),
      .d       (in_d[k]),
      .m       (out_m[63*k +: 63])
    );
  end

  assign out_valid   = v[STAGES-1];
  assign out_lane_en = en_q[STAGES-1];
  assign out_tag     = tag_q[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < STAGES; s++) occupancy = occupancy + 2'(v[s]);
  end

endmodule

// File: tb/tb_middle_nonlinear_pipe.sv
// Directed bench: three instances (STAGES=1,2,3), a beat scoreboard, golden M model and
// a reference AES S-box built from GF(2^8) inverse + affine for end-to-end checks.
module tb_middle_nonlinear_pipe;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [2:0]          vld, irdy, ovld, ordy;
  logic [107:0]        in_t;
  logic [3:0]          in_d, in_en;
  logic [7:0]          in_tag;
  logic [251:0]        om   [3];
  logic [3:0]          oen  [3];
  logic [7:0]          otag [3];
  logic [1:0]          occ  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    middle_nonlinear_pipe #(.LANES(4), .STAGES(g + 1), .TAG_W(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(vld[g]), .in_ready(irdy[g]),
      .in_t(in_t), .in_d(in_d), .in_lane_en(in_en), .in_tag(in_tag),
      .out_valid(ovld[g]), .out_ready(ordy[g]), .out_m(om[g]),
      .out_lane_en(oen[g]), .out_tag(otag[g]), .occupancy(occ[g]));
  end

  typedef struct { logic [31:0] b; logic [3:0] en; logic [7:0] tag; } beat_t;
  beat_t       q[$];
  logic [31:0] cur_b;
  logic [3:0]  cur_en;
  logic [7:0]  cur_tag;
  logic [7:0]  sref [256];
  int          n_chk = 0, n_err = 0, n_acc = 0, n_emit = 0;
  bit          stalled = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Top linear layer, U0 = MSB of the byte; returns {D, T26..T0}
  function automatic logic [27:0] top(input logic [7:0] x);
    logic U[8]; logic T[1:27]; logic [27:0] r;
    for (int i = 0; i < 8; i++) U[i] = x[7-i];
    T[1]=U[0]^U[3];   T[2]=U[0]^U[5];   T[3]=U[0]^U[6];   T[4]=U[3]^U[5];
    T[5]=U[4]^U[6];   T[6]=T[1]^T[5];   T[7]=U[1]^U[2];   T[8]=U[7]^T[6];
    T[9]=U[7]^T[7];   T[10]=T[6]^T[7];  T[11]=U[1]^U[5];  T[12]=U[2]^U[5];
    T[13]=T[3]^T[4];  T[14]=T[6]^T[11]; T[15]=T[5]^T[11]; T[16]=T[5]^T[12];
    T[17]=T[9]^T[16]; T[18]=U[3]^U[7];  T[19]=T[7]^T[18]; T[20]=T[1]^T[19];
    T[21]=U[6]^U[7];  T[22]=T[7]^T[21]; T[23]=T[2]^T[22]; T[24]=T[2]^T[10];
    T[25]=T[20]^T[17]; T[26]=T[3]^T[16]; T[27]=T[1]^T[12];
    for (int i = 1; i <= 27; i++) r[i-1] = T[i];
    r[27] = U[7];
    return r;
  endfunction

  function automatic logic [62:0] gold_m(input logic [27:0] td);
    logic T[1:27]; logic M[1:63]; logic D; logic [62:0] r;
    for (int i = 1; i <= 27; i++) T[i] = td[i-1];
    D = td[27];
    M[1]=T[13]&T[6];  M[2]=T[23]&T[8];  M[3]=T[14]^M[1];  M[4]=T[19]&D;
    M[5]=M[4]^M[1];   M[6]=T[3]&T[16];  M[7]=T[22]&T[9];  M[8]=T[26]^M[6];
    M[9]=T[20]&T[17]; M[10]=M[9]^M[6];  M[11]=T[1]&T[15]; M[12]=T[4]&T[27];
    M[13]=M[12]^M[11]; M[14]=T[2]&T[10]; M[15]=M[14]^M[11]; M[16]=M[3]^M[2];
    M[17]=M[5]^T[24]; M[18]=M[8]^M[7]; M[19]=M[10]^M[15]; M[20]=M[16]^M[13];
    M[21]=M[17]^M[15]; M[22]=M[18]^M[13]; M[23]=M[19]^T[25]; M[24]=M[22]^M[23];
    M[25]=M[22]&M[20]; M[26]=M[21]^M[25]; M[27]=M[20]^M[21]; M[28]=M[23]^M[25];
    M[29]=M[28]&M[27]; M[30]=M[26]&M[24]; M[31]=M[20]&M[23]; M[32]=M[27]&M[31];
    M[33]=M[27]^M[25]; M[34]=M[21]&M[22]; M[35]=M[24]&M[34]; M[36]=M[24]^M[25];
    M[37]=M[21]^M[29]; M[38]=M[32]^M[33]; M[39]=M[23]^M[30]; M[40]=M[35]^M[36];
    M[41]=M[38]^M[40]; M[42]=M[37]^M[39]; M[43]=M[37]^M[38]; M[44]=M[39]^M[40];
    M[45]=M[42]^M[41]; M[46]=M[44]&T[6]; M[47]=M[40]&T[8]; M[48]=M[39]&D;
    M[49]=M[43]&T[16]; M[50]=M[38]&T[9]; M[51]=M[37]&T[17]; M[52]=M[42]&T[15];
    M[53]=M[45]&T[27]; M[54]=M[41]&T[10]; M[55]=M[44]&T[13]; M[56]=M[40]&T[23];
    M[57]=M[39]&T[19]; M[58]=M[43]&T[3]; M[59]=M[38]&T[22]; M[60]=M[37]&T[20];
    M[61]=M[42]&T[1]; M[62]=M[45]&T[4]; M[63]=M[41]&T[2];
    for (int j = 1; j <= 63; j++) r[j-1] = M[j];
    return r;
  endfunction

  function automatic logic [7:0] bot(input logic [62:0] m);
    logic M[1:63]; logic L[30]; logic S[8];
    for (int j = 1; j <= 63; j++) M[j] = m[j-1];
    L[0]=M[61]^M[62]; L[1]=M[50]^M[56]; L[2]=M[46]^M[48]; L[3]=M[47]^M[55];
    L[4]=M[54]^M[58]; L[5]=M[49]^M[61]; L[6]=M[62]^L[5];  L[7]=M[46]^L[3];
    L[8]=M[51]^M[59]; L[9]=M[52]^M[53]; L[10]=M[53]^L[4]; L[11]=M[60]^L[2];
    L[12]=M[48]^M[51]; L[13]=M[50]^L[0]; L[14]=M[52]^M[61]; L[15]=M[55]^L[1];
    L[16]=M[56]^L[0]; L[17]=M[57]^L[1]; L[18]=M[58]^L[8]; L[19]=M[63]^L[4];
    L[20]=L[0]^L[1];  L[21]=L[1]^L[7];  L[22]=L[3]^L[12]; L[23]=L[18]^L[2];
    L[24]=L[15]^L[9]; L[25]=L[6]^L[10]; L[26]=L[7]^L[9];  L[27]=L[8]^L[10];
    L[28]=L[11]^L[14]; L[29]=L[11]^L[17];
    S[0]=L[6]^L[24];   S[1]=~(L[16]^L[26]); S[2]=~(L[19]^L[28]); S[3]=L[6]^L[21];
    S[4]=L[20]^L[22];  S[5]=L[25]^L[29];    S[6]=~(L[13]^L[27]); S[7]=~(L[6]^L[23]);
    return {S[0], S[1], S[2], S[3], S[4], S[5], S[6], S[7]};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      for (int n = 1; n <= 4; n++) s = s ^ ((inv << n) | (inv >> (8 - n)));
      sref[x] = s ^ 8'h63;
    end
  endtask

  task automatic drive(input logic [31:0] b, input logic [3:0] en, input logic [7:0] tag);
    logic [27:0] tt;
    cur_b = b; cur_en = en; cur_tag = tag;
    in_en = en; in_tag = tag;
    for (int k = 0; k < 4; k++) begin
      tt = top(b[8*k +: 8]);
      in_t[27*k +: 27] = tt[26:0];
      in_d[k] = tt[27];
    end
  endtask

  // One clock on instance d: score the output beat, record acceptance, advance.
  task automatic cyc(input int d, output bit acc);
    bit emit;
    logic [251:0] em;
    logic [7:0] b, s;
    #1;
    chk("occupancy", 256'(occ[d]), 256'(q.size()));
    if (stalled) chk("hold_valid", 256'(ovld[d]), 256'(1));
    acc  = vld[d] && irdy[d];
    emit = ovld[d] && ordy[d];
    if (ovld[d] && q.size() == 0) chk("spurious_valid", 256'(ovld[d]), 256'(0));
    else if (ovld[d]) begin
      em = '0;
      for (int k = 0; k < 4; k++)
        if (q[0].en[k]) em[63*k +: 63] = gold_m(top(q[0].b[8*k +: 8]));
      chk("out_m", 256'(om[d]), 256'(em));
      chk("out_tag", 256'(otag[d]), 256'(q[0].tag));
      chk("out_lane_en", 256'(oen[d]), 256'(q[0].en));
      for (int k = 0; k < 4; k++) if (q[0].en[k]) begin
        b = q[0].b[8*k +: 8];
        s = bot(om[d][63*k +: 63]);
        chk("sbox", 256'(s), 256'(sref[b]));
        if (b == 8'h00) chk("sbox_00", 256'(s), 256'(8'h63));
        if (b == 8'h01) chk("sbox_01", 256'(s), 256'(8'h7C));
        if (b == 8'h53) chk("sbox_53", 256'(s), 256'(8'hED));
      end
    end
    if (emit && q.size() > 0) begin
      void'(q.pop_front());
      n_emit++;
    end
    stalled = ovld[d] && !ordy[d];
    if (acc) begin
      q.push_back('{b: cur_b, en: cur_en, tag: cur_tag});
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    bit a;
    vld[d] = 1'b0; ordy[d] = 1'b1;
    for (int i = 0; i < 12 && q.size() > 0; i++) cyc(d, a);
    chk("drain_empty", 256'(q.size()), 256'(0));
  endtask

  initial begin
    bit a;
    int nsent, acc0, emit0, mx;
    build_sbox();
    reset_n = 1'b0; vld = '0; ordy = '0;
    drive(32'h0, 4'h0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(irdy), 256'(0));
    chk("rst_out_valid", 256'(ovld), 256'(0));
    for (int d = 0; d < 3; d++) begin
      chk("rst_occ", 256'(occ[d]), 256'(0));
      chk("rst_out_m", 256'(om[d]), 256'(0));
      chk("rst_out_tag", 256'(otag[d]), 256'(0));
    end
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 256'(irdy), 256'(3'b111));

    // Zero input, STAGES=2: two-cycle latency
    ordy[1] = 1'b1;
    drive(32'h0, 4'hF, 8'h5A);
    vld[1] = 1'b1;
    cyc(1, a);
    chk("zero_accept", 256'(a), 256'(1));
    vld[1] = 1'b0;
    chk("zero_lat1", 256'(ovld[1]), 256'(0));
    cyc(1, a);
    chk("zero_lat2", 256'(ovld[1]), 256'(1));
    chk("zero_m", 256'(om[1]), 256'(0));
    chk("zero_tag", 256'(otag[1]), 256'(8'h5A));
    drain(1);

    // Golden sweep: all 256 bytes, four per beat
    for (int i = 0; i < 64; i++) begin
      drive({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF, 8'(i));
      vld[1] = 1'b1;
      cyc(1, a);
    end
    drain(1);

    // Lane enable 1010
    drive(32'h44332211, 4'b1010, 8'h77);
    vld[1] = 1'b1;
    cyc(1, a);
    drain(1);

    // Backpressure, STAGES=3
    nsent = 0; emit0 = n_emit; ordy[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive({4{8'(8'h30 + nsent)}}, 4'hF, 8'(nsent));
      vld[2] = (nsent < 5);
      cyc(2, a);
      if (a) nsent++;
    end
    chk("bp_in_ready", 256'(irdy[2]), 256'(0));
    chk("bp_occ", 256'(occ[2]), 256'(3));
    chk("bp_accepted", 256'(nsent), 256'(3));
    ordy[2] = 1'b1;
    for (int c = 0; c < 40 && (nsent < 5 || q.size() > 0); c++) begin
      drive({4{8'(8'h30 + nsent)}}, 4'hF, 8'(nsent));
      vld[2] = (nsent < 5);
      cyc(2, a);
      if (a) nsent++;
    end
    vld[2] = 1'b0;
    chk("bp_sent_all", 256'(nsent), 256'(5));
    chk("bp_emitted", 256'(n_emit - emit0), 256'(5));
    drain(2);

    // Reset mid-flight, STAGES=3
    for (int i = 0; i < 2; i++) begin
      drive({4{8'(8'hA0 + i)}}, 4'hF, 8'(8'hE0 + i));
      vld[2] = 1'b1;
      cyc(2, a);
    end
    vld[2] = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 256'(irdy[2]), 256'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("midrst_valid", 256'(ovld[2]), 256'(0));
    chk("midrst_occ", 256'(occ[2]), 256'(0));
    chk("midrst_m", 256'(om[2]), 256'(0));
    chk("midrst_tag", 256'(otag[2]), 256'(0));
    q.delete(); stalled = 0;
    for (int c = 0; c < 6; c++) cyc(2, a);

    // STAGES=1: continuous input, random out_ready
    acc0 = n_acc; emit0 = n_emit; mx = 0;
    for (int c = 0; c < 300; c++) begin
      drive($urandom, 4'($urandom), 8'(c));
      vld[0] = 1'b1;
      ordy[0] = 1'($urandom_range(0, 1));
      if (int'(occ[0]) > mx) mx = int'(occ[0]);
      cyc(0, a);
    end
    drain(0);
    chk("s1_acc_eq_emit", 256'(n_acc - acc0), 256'(n_emit - emit0));
    chk("s1_occ_le1", 256'(mx <= 1), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/middle_nonlinear_pipe.md
Name: middle_nonlinear_pipe

Overview:
- Multi-lane, pipelined successor to the shared middle nonlinear section of the depth-16 Boyar–Peralta AES S-box.
- Takes LANES independent top-linear results (T0–T26 plus D, zero-based numbering) and produces the 63 shared nonlinear terms M0–M62 per lane.
- Sits between the top linear layer and the bottom linear layer in the multi-byte SubBytes datapath.
- Adds a valid/ready handshake, configurable register cut points, per-lane enables and a sideband tag, so SubBytes can be timing-closed at higher clock rates.

Parameters:
- LANES, 4, number of parallel S-box lanes (1..16).
- STAGES, 2, pipeline depth / latency in cycles (1, 2 or 3 only; any other value is an elaboration error).
- TAG_W, 8, width of the sideband tag carried alongside each beat (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_t  input  27*LANES  lane k uses bits [27k+26:27k], where bit i is T[i].
- in_d  input  LANES  lane k uses bit k as D.
- in_lane_en  input  LANES  per-lane enable, captured with the beat.
- in_tag  input  TAG_W  sideband tag, captured with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_m  output  63*LANES  lane k uses bits [63k+62:63k], where bit j is M[j].
- out_lane_en  output  LANES  lane enables of the output beat.
- out_tag  output  TAG_W  tag of the output beat.
- occupancy  output  2  number of valid beats held in the pipe (0..STAGES).

Behaviour:
- Function per lane: the depth-16 Boyar–Peralta middle nonlinear equations M1–M63, renumbered M0–M62 with T1–T27 renumbered T0–T26. This is pure GF(2) AND/XOR logic with no arithmetic carries.
- Cut points:
  - STAGES=1: all logic between input and a single output register.
  - STAGES=2: register after M19–M22. T0,T1,T2,T3,T5,T7,T8,T9,T12,T14,T15,T16,T18,T19,T21,T22,T26 and D are carried forward.
  - STAGES=3: the STAGES=2 cut, plus a second register after M36–M44 with the same carried T/D set.
- Each stage holds one beat, with a valid bit v[s]. There is no bubble collapse beyond the standard advance rule below.
- Advance rule: stage s loads when stage s+1 is empty or advancing. The last stage advances when out_valid && out_ready.
- in_ready = !v[0] || advance[0]. It is combinational from out_ready through the chain. There is no combinational path from in_valid to in_ready.
- An input beat is accepted when in_valid && in_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no stalls.
- Throughput: one beat per cycle while out_ready=1.
- Stall (out_valid=1, out_ready=0):
  - out_m, out_tag and out_lane_en are held stable.
  - Upstream stages fill, then in_ready drops.
  - No beat is lost or duplicated.
- Lane disable: if in_lane_en[k]=0 at acceptance, lane k's data registers load zero, so out_m for that lane is all zero. Disabled lanes must not toggle their data registers.
- Data registers load only on stage advance. Valid bits clear when a stage empties.
- occupancy = popcount(v). It updates on the same edge as v.
- Simultaneous accept and emit with a full pipe: occupancy stays unchanged.
- Reset (reset_n=0 at a clock edge, including mid-operation):
  - All v clear, so out_valid=0 and occupancy=0.
  - out_m, out_lane_en and out_tag are all 0.
  - in_ready is 0 while reset_n=0, then 1 on the first cycle after release.
  - In-flight beats are discarded.
- out_valid, once asserted, stays asserted until accepted (AXI-stream rule).

Test Plan:
- Zero input: STAGES=2, LANES=4, in_t=0, in_d=0, all lanes enabled, tag=0x5A.
  - out_valid rises exactly 2 cycles after acceptance.
  - out_m=0 and out_tag=0x5A.
- Golden sweep: all 256 bytes through the top-linear model into the lanes, with out_ready=1.
  - Each lane's out_m equals the bit-level M0–M62 golden model.
  - Feeding out_m to the bottom-linear model yields the AES S-box: 0x00→0x63, 0x01→0x7C, 0x53→0xED.
- Backpressure: STAGES=3, send 5 beats, hold out_ready=0 for 6 cycles, then release.
  - in_ready drops after 3 accepted beats and occupancy=3.
  - Outputs arrive in order with tags 0..4 and no duplicates.
- Lane enable: in_lane_en=4'b1010 with nonzero T on all lanes.
  - Lanes 0 and 2 output all-zero; lanes 1 and 3 match golden.
  - out_lane_en=4'b1010.
- Reset mid-flight: STAGES=3 with 2 beats in flight; assert reset_n=0 for one cycle.
  - Next cycle: out_valid=0, occupancy=0, out_m=0, out_tag=0.
  - No stale beat emerges afterwards.
- STAGES=1, continuous in_valid with random out_ready.
  - Accepted count equals emitted count.
  - occupancy never exceeds 1.
